phys_reg_release_queue: RTL and testbench
=========================================

# phys_reg_release_queue

Commit-side producer for the physical register free list. It receives up to two retiring instructions per cycle and captures the superseded physical register tag of each into a small in-order buffer. It drains one tag per cycle onto the free list's enqueue port (enqueue strobe plus tag). It sits between the retirement/ROB head logic and the free list, absorbing two-wide retire bursts against the free list's one-per-cycle enqueue.

## Interface
- NUM_PHYS_REGS, 64, number of physical registers.
- LOG_PHYS, $clog2(NUM_PHYS_REGS), tag width.
- DEPTH, 8, buffer entries; power of two, minimum 4.
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- Retire0_Valid_IN  in  1  retire slot 0 carries an instruction (older of the two).
- Retire0_HasDest_IN  in  1  slot 0 instruction wrote a register; only then is its old tag released.
- Retire0_OldPhys_IN  in  LOG_PHYS  slot 0 superseded physical tag.
- Retire1_Valid_IN / Retire1_HasDest_IN / Retire1_OldPhys_IN  in  1/1/LOG_PHYS  same for slot 1 (younger).
- Hold_IN  in  1  free-list side pause; no drain while high.
- Enqueue_OUT  out  1  registered; drives the free list enqueue strobe.
- Data_OUT  out  LOG_PHYS  registered; tag presented with Enqueue_OUT.
- Stall_OUT  out  1  retire backpressure; high when free slots < 2.
- Count_OUT  out  $clog2(DEPTH)+1  current occupancy.
- Overflow_OUT  out  1  sticky error flag.

## Operation
- State: circular buffer of DEPTH tags, head/tail pointers of $clog2(DEPTH) bits (natural modulo-DEPTH wrap), count register of $clog2(DEPTH)+1 bits.
- Request k is active when RetireK_Valid_IN && RetireK_HasDest_IN. Requests with HasDest=0 are ignored; no entry is written for them.
- Write order: slot 0 first, then slot 1, so tags leave in program order. A single active request uses one slot, whichever slot it arrives on.
- Free space for acceptance = DEPTH − count at the start of the cycle. A drain in the same cycle does not free space until the next cycle.
- Accepted requests: active requests in slot order, up to the free space. Any active request beyond that is dropped and sets Overflow_OUT. Overflow_OUT stays set until RESET.
- Drain: if count > 0 at the start of the cycle and Hold_IN = 0, the next edge sets Enqueue_OUT = 1 and Data_OUT = buf[head], and advances head. Otherwise Enqueue_OUT goes to 0 and Data_OUT holds its value.
- Entries written on an edge cannot drain on the same edge.
- count_next = count + accepted − drained. Both may be nonzero in one cycle.
- Stall_OUT = (DEPTH − count) < 2. It is a combinational decode of the count register only, with no input dependence.
- Count_OUT = count.
- Retire logic must not present active requests while Stall_OUT = 1. If it does, the overflow rule applies.

## Timing
- Reset (RESET high at a posedge):
  - head, tail, count = 0.
  - Enqueue_OUT = 0, Data_OUT = 0, Overflow_OUT = 0.
  - Stall_OUT = 0, Count_OUT = 0.
  - RESET overrides all inputs on that edge.
- Reset mid-operation discards all buffered tags. The free list is reset on the same edge and re-seeds all registers, so nothing is lost.
- Latency: a tag sampled at edge E0 into an empty buffer, with Hold_IN low, appears as Enqueue_OUT = 1 / Data_OUT = tag after edge E1. The free list captures it at E2.
- Throughput: one release per cycle sustained. Enqueue_OUT is high for exactly one cycle per tag, and back-to-back cycles are allowed.
- Hold_IN is sampled at the drain edge. Asserting it stops the next Enqueue_OUT, with no partial transfers.
- Full buffer (count = DEPTH): all active requests drop. Drain continues normally.
- Empty buffer with Hold_IN = 0: Enqueue_OUT = 0, and Data_OUT is don't-care to the consumer.

## Test plan
- Single release with DEPTH = 8: reset, then slot 0 only (Valid = 1, HasDest = 1, tag 5) for one cycle → after E1, Enqueue_OUT = 1 and Data_OUT = 5 for exactly one cycle; Count_OUT goes 1 then 0.
- Ordering and wrap: both slots active for 12 cycles with tags 0..23 (slot 0 even, slot 1 odd), Stall_OUT honored → Enqueue_OUT emits 0,1,2,…,23 in order on consecutive cycles; pointers wrap; no Overflow_OUT.
- Backpressure:
  - Hold_IN = 1, then 3 cycles of dual retire → Count_OUT = 6, Stall_OUT = 0.
  - A 4th dual retire → Count_OUT = 8, Stall_OUT = 1.
  - Drop Hold_IN → 8 consecutive releases in order; Stall_OUT falls once Count_OUT ≤ 6.
- Overflow: Hold_IN = 1 with Count_OUT = 7, then present dual active retire (tags 40, 41) → 40 accepted, Count_OUT = 8, 41 dropped, Overflow_OUT = 1 and it stays set.
- Filtering: slot 0 Valid = 1 / HasDest = 0 (tag 3), slot 1 Valid = 1 / HasDest = 1 (tag 9) → only 9 is released; Count_OUT peaks at 1.
- Reset mid-drain: Count_OUT = 4 with draining in progress, RESET high for one cycle → next cycle Enqueue_OUT = 0, Count_OUT = 0, Overflow_OUT = 0; no stale tag is ever emitted afterwards.

Source files
------------

// File: rtl/phys_reg_release_queue.sv
// Commit-side release queue: captures superseded physical tags from up to two
// retiring instructions per cycle and drains one per cycle to the free list.
module phys_reg_release_queue #(
  parameter int unsigned NUM_PHYS_REGS = 64,
  parameter int unsigned LOG_PHYS      = $clog2(NUM_PHYS_REGS),
  parameter int unsigned DEPTH         = 8
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      Retire0_Valid_IN,
  input  logic                      Retire0_HasDest_IN,
  input  logic [LOG_PHYS-1:0]       Retire0_OldPhys_IN,
  input  logic                      Retire1_Valid_IN,
  input  logic                      Retire1_HasDest_IN,
  input  logic [LOG_PHYS-1:0]       Retire1_OldPhys_IN,
  input  logic                      Hold_IN,
  output logic                      Enqueue_OUT,
  output logic [LOG_PHYS-1:0]       Data_OUT,
  output logic                      Stall_OUT,
  output logic [$clog2(DEPTH):0]    Count_OUT,
  output logic                      Overflow_OUT
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [LOG_PHYS-1:0] buf_q [DEPTH];
  logic [LOG_PHYS-1:0] buf_d [DEPTH];
  logic [PW-1:0]       head_q, head_d;
  logic [PW-1:0]       tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic                enq_q, enq_d;
  logic [LOG_PHYS-1:0] data_q, data_d;
  logic                ovf_q, ovf_d;

  logic [CW-1:0]       free_c;
  logic                req0, req1, drain;
  logic [1:0]          n_req, n_acc;
  logic [LOG_PHYS-1:0] first_tag;

  // Free space is judged on the start-of-cycle count; a same-cycle drain does not help.
  assign free_c = CW'(DEPTH) - count_q;

  always_comb begin
    req0      = Retire0_Valid_IN & Retire0_HasDest_IN;
    req1      = Retire1_Valid_IN & Retire1_HasDest_IN;
    n_req     = {1'b0, req0} + {1'b0, req1};
    first_tag = req0 ? Retire0_OldPhys_IN : Retire1_OldPhys_IN;

    if (free_c >= CW'(2))      n_acc = n_req;
    else if (free_c == CW'(1)) n_acc = (n_req != 2'd0) ? 2'd1 : 2'd0;
    else                       n_acc = 2'd0;

    drain = (count_q != CW'(0)) & ~Hold_IN;

    // Slot 1 only lands in the second position when slot 0 also wrote.
    buf_d = buf_q;
    if (n_acc != 2'd0) buf_d[tail_q] = first_tag;
    if (n_acc == 2'd2) buf_d[tail_q + PW'(1)] = Retire1_OldPhys_IN;

    tail_d  = tail_q + PW'(n_acc);
    head_d  = head_q + PW'(drain);
    count_d = count_q + CW'(n_acc) - CW'(drain);
    enq_d   = drain;
    data_d  = drain ? buf_q[head_q] : data_q;
    ovf_d   = ovf_q | (n_req != n_acc);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < int'(DEPTH); i++) buf_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      enq_q   <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      enq_q   <= enq_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Enqueue_OUT  = enq_q;
  assign Data_OUT     = data_q;
  assign Count_OUT    = count_q;
  assign Overflow_OUT = ovf_q;
  assign Stall_OUT    = free_c < CW'(2);

endmodule

// File: tb/tb_phys_reg_release_queue.sv
// Bench for phys_reg_release_queue: vector table, directed corner sequences and
// random traffic against a queue-based reference model.
module tb_phys_reg_release_queue;

  localparam int DEPTH = 8;
  localparam int LP    = 6;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          r0_v, r0_h, r1_v, r1_h, hold;
  logic [LP-1:0] r0_t, r1_t;
  logic          enq_o, stall_o, ovf_o;
  logic [LP-1:0] data_o;
  logic [3:0]    count_o;

  phys_reg_release_queue #(.NUM_PHYS_REGS(64), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET),
    .Retire0_Valid_IN(r0_v), .Retire0_HasDest_IN(r0_h), .Retire0_OldPhys_IN(r0_t),
    .Retire1_Valid_IN(r1_v), .Retire1_HasDest_IN(r1_h), .Retire1_OldPhys_IN(r1_t),
    .Hold_IN(hold),
    .Enqueue_OUT(enq_o), .Data_OUT(data_o), .Stall_OUT(stall_o),
    .Count_OUT(count_o), .Overflow_OUT(ovf_o)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          v0, h0;
    logic [LP-1:0] t0;
    logic          v1, h1;
    logic [LP-1:0] t1;
    logic          hold;
    logic          e_enq;
    logic [LP-1:0] e_data;
    logic [3:0]    e_count;
    logic          e_stall;
    logic          e_ovf;
  } vec_t;

  vec_t vt[6];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: program-ordered FIFO of tags plus sticky/held output state.
  logic [LP-1:0] mq[$];
  logic          m_enq;
  logic [LP-1:0] m_data;
  logic          m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic model_check(input string tag);
    check({tag, " enq"},   32'(enq_o),   32'(m_enq));
    check({tag, " data"},  32'(data_o),  32'(m_data));
    check({tag, " count"}, 32'(count_o), 32'(mq.size()));
    check({tag, " stall"}, 32'(stall_o), 32'((DEPTH - mq.size()) < 2));
    check({tag, " ovf"},   32'(ovf_o),   32'(m_ovf));
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    r0_v = 0; r0_h = 0; r0_t = '0; r1_v = 0; r1_h = 0; r1_t = '0; hold = 0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    mq.delete();
    m_enq = 0; m_data = '0; m_ovf = 0;
    model_check("reset");
  endtask

  task automatic step(input logic v0, input logic h0, input logic [LP-1:0] t0,
                      input logic v1, input logic h1, input logic [LP-1:0] t1,
                      input logic hd, input string tag);
    int fr;
    r0_v = v0; r0_h = h0; r0_t = t0; r1_v = v1; r1_h = h1; r1_t = t1; hold = hd;
    @(posedge CLK); #1;
    fr = DEPTH - mq.size();
    if (mq.size() > 0 && !hd) begin
      m_enq  = 1'b1;
      m_data = mq.pop_front();
    end else begin
      m_enq = 1'b0;
    end
    if (v0 && h0) begin
      if (fr > 0) begin mq.push_back(t0); fr--; end
      else m_ovf = 1'b1;
    end
    if (v1 && h1) begin
      if (fr > 0) begin mq.push_back(t1); fr--; end
      else m_ovf = 1'b1;
    end
    model_check(tag);
  endtask

  task automatic idle(input int n, input logic hd, input string tag);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, '0, hd, tag);
  endtask

  initial begin
    int next_tag;
    int issued;

    // Single release followed by filtered dual retire, with explicit expectations.
    vt[0] = '{1,1,6'd5, 0,0,6'd0, 0,  0,6'd0,4'd1,0,0};
    vt[1] = '{0,0,6'd0, 0,0,6'd0, 0,  1,6'd5,4'd0,0,0};
    vt[2] = '{0,0,6'd0, 0,0,6'd0, 0,  0,6'd5,4'd0,0,0};
    vt[3] = '{1,0,6'd3, 1,1,6'd9, 0,  0,6'd5,4'd1,0,0};
    vt[4] = '{0,0,6'd0, 0,0,6'd0, 0,  1,6'd9,4'd0,0,0};
    vt[5] = '{0,0,6'd0, 0,0,6'd0, 0,  0,6'd9,4'd0,0,0};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(vt[i].v0, vt[i].h0, vt[i].t0, vt[i].v1, vt[i].h1, vt[i].t1, vt[i].hold, "vec");
      check($sformatf("vec%0d enq", i),   32'(enq_o),   32'(vt[i].e_enq));
      check($sformatf("vec%0d data", i),  32'(data_o),  32'(vt[i].e_data));
      check($sformatf("vec%0d count", i), 32'(count_o), 32'(vt[i].e_count));
      check($sformatf("vec%0d stall", i), 32'(stall_o), 32'(vt[i].e_stall));
      check($sformatf("vec%0d ovf", i),   32'(ovf_o),   32'(vt[i].e_ovf));
    end

    // Ordering and pointer wrap: 12 dual retires honoring backpressure.
    do_reset();
    next_tag = 0;
    issued = 0;
    for (int cyc = 0; cyc < 60 && next_tag < 24; cyc++) begin
      if (issued < 12 && (DEPTH - mq.size()) >= 2) begin
        step(1, 1, LP'(2 * issued), 1, 1, LP'(2 * issued + 1), 0, "order");
        issued++;
      end else begin
        step(0, 0, '0, 0, 0, '0, 0, "order");
      end
      if (cyc >= 1 && next_tag < 24) begin
        check("order consecutive", 32'(enq_o), 32'd1);
        if (enq_o) begin
          check("order tag", 32'(data_o), 32'(next_tag));
          next_tag++;
        end
      end
    end
    check("order total", 32'(next_tag), 32'd24);
    check("order no ovf", 32'(ovf_o), 32'd0);

    // Backpressure: fill under hold, then drain eight in order.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, LP'(10 + 2 * i), 1, 1, LP'(11 + 2 * i), 1, "bp fill");
    check("bp count6", 32'(count_o), 32'd6);
    check("bp stall low", 32'(stall_o), 32'd0);
    step(1, 1, 6'd16, 1, 1, 6'd17, 1, "bp fill");
    check("bp count8", 32'(count_o), 32'd8);
    check("bp stall high", 32'(stall_o), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, '0, 0, 0, '0, 0, "bp drain");
      check("bp drain tag", 32'(data_o), 32'(10 + i));
      check("bp drain stall", 32'(stall_o), 32'(i < 1));
    end
    idle(1, 0, "bp empty");

    // Overflow: count 7 under hold, then dual retire 40/41.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, LP'(20 + 2 * i), 1, 1, LP'(21 + 2 * i), 1, "ovf fill");
    step(0, 0, '0, 1, 1, 6'd26, 1, "ovf fill");
    check("ovf count7", 32'(count_o), 32'd7);
    step(1, 1, 6'd40, 1, 1, 6'd41, 1, "ovf hit");
    check("ovf count8", 32'(count_o), 32'd8);
    check("ovf set", 32'(ovf_o), 32'd1);
    for (int i = 0; i < 8; i++) step(0, 0, '0, 0, 0, '0, 0, "ovf drain");
    check("ovf last tag", 32'(data_o), 32'd40);
    idle(2, 0, "ovf after");
    check("ovf sticky", 32'(ovf_o), 32'd1);

    // Reset in the middle of a drain.
    do_reset();
    step(1, 1, 6'd30, 1, 1, 6'd31, 1, "mid fill");
    step(1, 1, 6'd32, 1, 1, 6'd33, 1, "mid fill");
    step(1, 1, 6'd34, 0, 0, '0, 0, "mid drain");
    check("mid count4", 32'(count_o), 32'd4);
    check("mid draining", 32'(enq_o), 32'd1);
    do_reset();
    check("mid rst enq", 32'(enq_o), 32'd0);
    check("mid rst count", 32'(count_o), 32'd0);
    idle(6, 0, "mid stale");

    // Random traffic; backpressure occasionally ignored to exercise drops.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic v0, h0, v1, h1, hd;
      v0 = 1'($urandom_range(0, 1));
      h0 = 1'($urandom_range(0, 3) != 0);
      v1 = 1'($urandom_range(0, 1));
      h1 = 1'($urandom_range(0, 3) != 0);
      hd = 1'($urandom_range(0, 3) == 0);
      if ((DEPTH - mq.size()) < 2 && $urandom_range(0, 19) != 0) begin
        v0 = 0; v1 = 0;
      end
      if (i == 200) do_reset();
      step(v0, h0, LP'($urandom), v1, h1, LP'($urandom), hd, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
